// File: rtl/pc_update_unit.sv
// PC register with mode-selected next-PC, one-cycle flush after redirects and sticky misalign error.
// Optional PC_PERF_CNT_EN adds saturating redirect/stall counters with a synchronous clear.
module pc_update_unit #(
  parameter int unsigned      WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned      INC        = 4,
  parameter int unsigned      ALIGN_BITS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       pc_we_i,
  input  logic             alu_zero_i,
  input  logic             stall_i,
  input  logic [WIDTH-1:0] branch_off_i,
  input  logic [WIDTH-1:0] jump_target_i,
  input  logic [WIDTH-1:0] reg_target_i,
  input  logic             err_clr_i,
`ifdef PC_PERF_CNT_EN
  input  logic             cnt_clr_i,
  output logic [31:0]      redirect_cnt_o,
  output logic [31:0]      stall_cnt_o,
`endif
  output logic [WIDTH-1:0] pc_o,
  output logic [WIDTH-1:0] pc_plus_o,
  output logic             taken_o,
  output logic             flush_o,
  output logic             err_o,
  output logic [WIDTH-1:0] err_pc_o
);

  typedef enum logic [1:0] {StRun, StFlush, StError} state_e;

  localparam logic [WIDTH-1:0] AlignMask = (WIDTH'(1) << ALIGN_BITS) - WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d, err_pc_q, err_pc_d, target;
  logic             err_q, err_d;
  logic             update, redirect, misaligned, active, commit;

  assign pc_plus_o = pc_q + WIDTH'(INC);

  // Target selection; a non-taken branch falls through to the sequential target.
  always_comb begin
    target   = pc_plus_o;
    update   = 1'b1;
    redirect = 1'b0;
    unique case (pc_we_i)
      3'd1: ;
      3'd2: if (alu_zero_i) begin
        target   = pc_plus_o + branch_off_i;
        redirect = 1'b1;
      end
      3'd3: if (!alu_zero_i) begin
        target   = pc_plus_o + branch_off_i;
        redirect = 1'b1;
      end
      3'd4: begin
        target   = jump_target_i;
        redirect = 1'b1;
      end
      3'd5: begin
        target   = reg_target_i;
        redirect = 1'b1;
      end
      default: update = 1'b0;
    endcase
  end

  assign misaligned = update && (|(target & AlignMask));
  assign active     = (state_q != StError) && !stall_i;
  assign commit     = active && update && !misaligned;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StRun;
      pc_q     <= RESET_PC;
      err_q    <= 1'b0;
      err_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      err_q    <= err_d;
      err_pc_q <= err_pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StError: if (err_clr_i) state_d = StRun;
      default: if (!stall_i) begin
        if (misaligned)            state_d = StError;
        else if (update && redirect) state_d = StFlush;
        else                       state_d = StRun;
      end
    endcase
  end

  always_comb begin
    pc_d     = commit ? target : pc_q;
    err_d    = err_q;
    err_pc_d = err_pc_q;
    if (state_q == StError) begin
      if (err_clr_i) err_d = 1'b0;
    end else if (active && misaligned) begin
      err_d    = 1'b1;
      err_pc_d = pc_q;
    end
  end

  always_comb begin
    pc_o     = pc_q;
    flush_o  = (state_q == StFlush);
    taken_o  = (state_q == StFlush);
    err_o    = err_q;
    err_pc_o = err_pc_q;
  end

`ifdef PC_PERF_CNT_EN
  logic [31:0] redirect_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_cnt_q <= '0;
      stall_cnt_q    <= '0;
    end else if (cnt_clr_i) begin
      redirect_cnt_q <= '0;
      stall_cnt_q    <= '0;
    end else begin
      if (commit && redirect && (redirect_cnt_q != '1)) redirect_cnt_q <= redirect_cnt_q + 32'd1;
      if (stall_i && (state_q != StError) && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign redirect_cnt_o = redirect_cnt_q;
  assign stall_cnt_o    = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pc_update_unit.sv
// Bench for pc_update_unit: directed scenarios plus random traffic against a behavioural model.
module tb_pc_update_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  pc_we;
  logic        alu_zero, stall, err_clr;
  logic [31:0] branch_off, jump_target, reg_target;
  logic [31:0] pc, pc_plus, err_pc;
  logic        taken, flush, err;
`ifdef PC_PERF_CNT_EN
  logic        cnt_clr = 1'b0;
  logic [31:0] redirect_cnt, stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Reference state: PC, whether the last edge committed a redirect, sticky error.
  logic [31:0] m_pc, m_err_pc;
  bit          m_flush, m_err;

  always #5 clk = ~clk;

  pc_update_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_we_i       (pc_we),
    .alu_zero_i    (alu_zero),
    .stall_i       (stall),
    .branch_off_i  (branch_off),
    .jump_target_i (jump_target),
    .reg_target_i  (reg_target),
    .err_clr_i     (err_clr),
`ifdef PC_PERF_CNT_EN
    .cnt_clr_i     (cnt_clr),
    .redirect_cnt_o(redirect_cnt),
    .stall_cnt_o   (stall_cnt),
`endif
    .pc_o          (pc),
    .pc_plus_o     (pc_plus),
    .taken_o       (taken),
    .flush_o       (flush),
    .err_o         (err),
    .err_pc_o      (err_pc)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_model();
    check_eq("pc", pc, m_pc);
    check_eq("pc_plus", pc_plus, m_pc + 32'd4);
    check_eq("flush", {31'd0, flush}, {31'd0, m_flush});
    check_eq("taken", {31'd0, taken}, {31'd0, m_flush});
    check_eq("err", {31'd0, err}, {31'd0, m_err});
    check_eq("err_pc", err_pc, m_err_pc);
  endtask

  task automatic model_reset();
    m_pc = 32'd0; m_err_pc = 32'd0; m_flush = 0; m_err = 0;
  endtask

  // Apply one cycle of inputs, advance the model, compare 1 time unit after the edge.
  task automatic step(input logic [2:0] we, input logic z, input logic st, input logic [31:0] bo,
                      input logic [31:0] jt, input logic [31:0] rt, input logic clr);
    logic [31:0] tgt;
    bit          upd, redir;
    pc_we = we; alu_zero = z; stall = st; branch_off = bo;
    jump_target = jt; reg_target = rt; err_clr = clr;
    @(posedge clk);
    if (m_err) begin
      if (clr) m_err = 0;
    end else if (!st) begin
      upd = 1; redir = 0; tgt = m_pc + 32'd4;
      if ((we == 3'd2 && z) || (we == 3'd3 && !z)) begin
        tgt = m_pc + 32'd4 + bo; redir = 1;
      end else if (we == 3'd4) begin
        tgt = jt; redir = 1;
      end else if (we == 3'd5) begin
        tgt = rt; redir = 1;
      end else if (we == 3'd0 || we > 3'd5) begin
        upd = 0;
      end
      if (upd && (tgt % 4 != 0)) begin
        m_err = 1; m_err_pc = m_pc; m_flush = 0;
      end else begin
        if (upd) m_pc = tgt;
        m_flush = upd && redir;
      end
    end
    #1;
    check_model();
  endtask

  task automatic idle();
    step(3'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic jump(input logic [31:0] t);
    step(3'd4, 1'b0, 1'b0, 32'd0, t, 32'd0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; pc_we = '0; alu_zero = 0; stall = 0; err_clr = 0;
    branch_off = '0; jump_target = '0; reg_target = '0;
    model_reset();
    #8;
    check_model();
    #4 rst_n = 1'b1;
    @(negedge clk);
    #3; // align to 1 unit after the next posedge cadence
    @(posedge clk); #1;

    // Sequential run from reset
    for (int i = 0; i < 3; i++) step(3'd1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    check_eq("seq_pc12", pc, 32'h0000_000C);

    // Taken and non-taken zero branch from 0x10
    jump(32'h10); idle();
    step(3'd2, 1'b1, 1'b0, 32'h20, 32'd0, 32'd0, 1'b0);
    check_eq("beq_taken_pc", pc, 32'h34);
    check_eq("beq_flush", {31'd0, flush}, 32'd1);
    idle();
    check_eq("beq_flush_drop", {31'd0, flush}, 32'd0);
    jump(32'h10); idle();
    step(3'd2, 1'b0, 1'b0, 32'h20, 32'd0, 32'd0, 1'b0);
    check_eq("beq_nt_pc", pc, 32'h14);

    // Back-to-back redirects keep flush high
    step(3'd3, 1'b0, 1'b0, 32'h8, 32'd0, 32'd0, 1'b0);
    step(3'd4, 1'b0, 1'b0, 32'd0, 32'h100, 32'd0, 1'b0);
    check_eq("b2b_flush", {31'd0, flush}, 32'd1);
    idle();
    check_eq("b2b_pc", pc, 32'h100);

    // Misaligned jump register then recovery
    jump(32'h40); idle();
    step(3'd5, 1'b0, 1'b0, 32'd0, 32'd0, 32'h102, 1'b0);
    check_eq("mis_err", {31'd0, err}, 32'd1);
    check_eq("mis_err_pc", err_pc, 32'h40);
    step(3'd1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    check_eq("err_hold_pc", pc, 32'h40);
    step(3'd1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
    check_eq("err_clr", {31'd0, err}, 32'd0);
    step(3'd1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    check_eq("err_resume_pc", pc, 32'h44);

    // Stalled jump is dropped
    step(3'd4, 1'b0, 1'b1, 32'd0, 32'h200, 32'd0, 1'b0);
    step(3'd4, 1'b0, 1'b1, 32'd0, 32'h200, 32'd0, 1'b0);
    check_eq("stall_pc", pc, 32'h44);
    step(3'd1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    check_eq("post_stall_pc", pc, 32'h48);

    // Wrap-around
    jump(32'hFFFF_FFFC); idle();
    step(3'd1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    check_eq("wrap_pc", pc, 32'h0);

    // Random traffic, mostly aligned targets, some near the top of the address space
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] bo, jt, rt;
      bo = $urandom(); jt = $urandom(); rt = $urandom();
      if ($urandom_range(0, 3) != 0) begin
        bo[1:0] = 2'b00; jt[1:0] = 2'b00; rt[1:0] = 2'b00;
      end
      if ($urandom_range(0, 15) == 0) jt[31:8] = 24'hFF_FFFF;
      step(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0),
           bo, jt, rt, ($urandom_range(0, 3) == 0));
    end

    // Asynchronous reset in the middle of a FLUSH cycle
    step(3'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
    jump(32'h80);
    check_eq("pre_rst_flush", {31'd0, flush}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("async_rst_pc", pc, 32'h0);
    check_eq("async_rst_flush", {31'd0, flush}, 32'd0);
    check_model();
    @(posedge clk); #1 rst_n = 1'b1;
    step(3'd1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    check_eq("post_rst_pc", pc, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_update_unit.md
Name: pc_update_unit

Overview:
Parametrised successor to the PC write-enable handler. Owns the PC register for the CPU and selects the next PC from a 3-bit update mode: hold, sequential, conditional branch on zero or non-zero, absolute jump, and jump register. It adds a one-cycle flush pulse after every redirect and a sticky misalignment error state. It sits between the control FSM/ALU and instruction memory.

Parameters:
WIDTH, 32, PC and target width in bits (≥8).
RESET_PC, 0, PC value loaded on reset (must be aligned).
INC, 4, sequential increment; power of two, ≥1.
ALIGN_BITS, 2, low PC bits that must be zero; 0 disables the alignment check.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
pc_we  input  3  update mode (encoding below)
alu_zero  input  1  ALU zero flag, same cycle as pc_we
stall  input  1  freeze PC this cycle; has priority over pc_we
branch_off  input  WIDTH  pre-extended, pre-shifted branch offset
jump_target  input  WIDTH  absolute jump target
reg_target  input  WIDTH  register jump target
err_clr  input  1  clears the error state
pc  output  WIDTH  current PC (registered)
pc_plus  output  WIDTH  pc + INC (combinational from pc)
taken  output  1  registered; 1 for the cycle after a redirect commits
flush  output  1  registered; 1-cycle pulse after a redirect commits
err  output  1  registered; sticky misaligned-target flag
err_pc  output  WIDTH  registered; PC of the instruction that faulted

Behaviour:
- Reset (rst_n=0, asynchronous): pc=RESET_PC; taken=0; flush=0; err=0; err_pc=0; state=RUN.
- pc_we encoding:
  - 0: hold.
  - 1: sequential, pc<=pc+INC.
  - 2: branch if alu_zero=1, pc<=pc_plus+branch_off; otherwise sequential.
  - 3: branch if alu_zero=0, same targets as mode 2.
  - 4: jump, pc<=jump_target.
  - 5: jump register, pc<=reg_target.
  - 6 and 7: reserved; treated as hold with no other effect.
- All arithmetic is modulo 2^WIDTH; wrap-around is silent (0xFFFFFFFC+4 -> 0).
- A redirect is a taken branch or mode 4/5. Non-taken branches count as sequential.
- States:
  - RUN: normal updates.
  - FLUSH: entered after a redirect commits; lasts exactly one cycle, then returns to RUN.
  - ERROR: PC frozen.
- In FLUSH the unit still accepts pc_we and stall, so back-to-back redirects are legal. A redirect taken in FLUSH re-enters FLUSH.
- flush and taken are 1 exactly while in FLUSH (one cycle after the commit edge).
- stall=1: pc, state, and outputs are held (flush stays high if already in FLUSH, for one more cycle). The stalled update is dropped, not queued.
- Alignment: if ALIGN_BITS>0 and the selected next PC has any of its low ALIGN_BITS bits set, the PC is not updated. Instead: err<=1, err_pc<=pc, state goes to ERROR, and flush is not asserted. The check also applies to sequential targets.
- ERROR: pc held; pc_we and stall ignored. err_clr=1 moves to RUN with err<=0 on that edge and leaves pc unchanged. err_clr outside ERROR has no effect.
- Priority per edge: reset > ERROR hold/err_clr > stall > pc_we.
- Reset mid-operation discards any FLUSH or ERROR state immediately.

Optional Feature:
PC_PERF_CNT_EN.
- Defined: adds output ports redirect_cnt (32) and stall_cnt (32), plus input cnt_clr (1).
  - redirect_cnt increments on each committed redirect.
  - stall_cnt increments on each cycle with stall=1 in RUN or FLUSH.
  - Both saturate at 0xFFFFFFFF, reset to 0, and clear synchronously on cnt_clr. cnt_clr has priority over increment.
- Undefined: these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- Reset then 3 cycles of pc_we=1 -> pc = 0, 4, 8, 12; flush=0 throughout.
- pc=0x10, pc_we=2, alu_zero=1, branch_off=0x20 -> next pc=0x34, flush=taken=1 for exactly one cycle; same stimulus with alu_zero=0 -> pc=0x14, flush=0.
- pc_we=3 with alu_zero=0, then pc_we=4 with jump_target=0x100 in the FLUSH cycle -> two redirects; flush stays high 2 consecutive cycles; pc ends at 0x100.
- pc_we=5, reg_target=0x102 at pc=0x40 -> pc stays 0x40, err=1, err_pc=0x40; further pc_we=1 ignored; err_clr=1 -> err=0; next pc_we=1 -> pc=0x44.
- stall=1 with pc_we=4 for 2 cycles, then stall=0 with pc_we=1 -> pc unchanged during the stall, then +4; the dropped jump never takes effect.
- pc=0xFFFFFFFC, pc_we=1 -> pc=0; rst_n low mid-FLUSH -> pc=RESET_PC and flush=0 immediately, without waiting for a clock edge.
